// File: rtl/plic_pkg.sv
// Shared types and helpers for the PLIC source gateway.
// Channel state encoding and edge-counter sizing.
package plic_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    CLAIMED = 2'd2
  } plic_gw_state_e;

  function automatic int plic_cnt_width(input int max_pending);
    return $clog2(max_pending + 1);
  endfunction

endpackage

// File: rtl/plic_source_channel.sv
// One interrupt source: synchroniser, edge detect, outstanding-edge
// counter and pending/claimed handshake FSM.
module plic_source_channel
  import plic_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_PENDING = 7
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic irq_i,
  input  logic edge_mode_i,
  input  logic claim_i,
  input  logic completed_i,
  output logic pending_o,
  output logic overflow_o
);

  localparam int CW = plic_cnt_width(MAX_PENDING);
  localparam logic [CW-1:0] MAXC = CW'(MAX_PENDING);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic [CW-1:0]          r_cnt;
  logic                   r_ovf;
  plic_gw_state_e         r_state;

  logic w_sync;
  logic w_edge;
  logic w_dec;
  logic w_req;
  logic w_sat;

  assign w_sync = r_sync[SYNC_STAGES-1];
  assign w_edge = w_sync & ~r_prev;
  assign w_dec  = (r_state == PENDING) & claim_i;
  assign w_sat  = (r_cnt == MAXC);
  assign w_req  = edge_mode_i ? ((r_cnt != '0) | w_edge) : w_sync;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], irq_i};
      r_prev <= w_sync;
    end
  end

  // Edge and claim in the same cycle cancel out.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_ovf <= edge_mode_i & w_edge & ~w_dec & w_sat;
      if (!edge_mode_i) begin
        r_cnt <= '0;
      end else if (w_edge & ~w_dec) begin
        if (!w_sat) r_cnt <= r_cnt + 1'b1;
      end else if (~w_edge & w_dec) begin
        if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      unique case (r_state)
        IDLE:    if (w_req)       r_state <= PENDING;
        PENDING: if (claim_i)     r_state <= CLAIMED;
        CLAIMED: if (completed_i) r_state <= IDLE;
        default:                  r_state <= IDLE;
      endcase
    end
  end

  assign pending_o  = (r_state == PENDING);
  assign overflow_o = r_ovf;

endmodule

// File: rtl/plic_source_gateway.sv
// PLIC gateway array: one conditioning channel per interrupt source.
// Only generate and array wiring live here.
module plic_source_gateway
  import plic_pkg::*;
#(
  parameter int NUM_SOURCES = 1,
  parameter int SYNC_STAGES = 2,
  parameter int MAX_PENDING = 7
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NUM_SOURCES-1:0] irq_sources_i,
  input  logic [NUM_SOURCES-1:0] edge_mode_i,
  input  logic                   claim_i       [NUM_SOURCES],
  input  logic                   completed_i   [NUM_SOURCES],
  output logic                   irq_pending_o [NUM_SOURCES],
  output logic [NUM_SOURCES-1:0] overflow_o
);

  for (genvar i = 0; i < NUM_SOURCES; i++) begin : g_src
    plic_source_channel #(
      .SYNC_STAGES(SYNC_STAGES),
      .MAX_PENDING(MAX_PENDING)
    ) u_ch (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .irq_i      (irq_sources_i[i]),
      .edge_mode_i(edge_mode_i[i]),
      .claim_i    (claim_i[i]),
      .completed_i(completed_i[i]),
      .pending_o  (irq_pending_o[i]),
      .overflow_o (overflow_o[i])
    );
  end

endmodule
